fir_sched: RTL and testbench
============================

FIR_SCHED -- requirements
Module: fir_sched

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 4, meaning cycles from a lane issue to its product being valid at the accumulator (legal 1..8).
REQ-002 SHALL have parameter NTAP, default 29, meaning filter tap count; the only legal value is 29.
REQ-003 Clk  in  1  single clock, rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 FifoEmpty  in  1  input sample FIFO empty flag.
REQ-006 FifoRd  out  1  pop one I/Q sample from the FIFO.
REQ-007 ShiftEn  out  1  shift the 29-entry delay line by one, with the popped sample entering entry 0.
REQ-008 PushCoef  in  1  coefficient write request, held high for every write cycle.
REQ-009 CoefWrEn  out  1  coefficient RAM write enable.
REQ-010 CoefBusy  out  1  high whenever a write request is not being accepted.
REQ-011 AddrA  out  25  five 5-bit pre-adder operand-A tap indices; lane l occupies bits [5l+4:5l].
REQ-012 AddrB  out  25  five 5-bit operand-B tap indices, same packing as AddrA.
REQ-013 CoefSel  out  20  five 4-bit coefficient pair indices, 4 bits per lane.
REQ-014 CenterZero  out  1  force lane 4 operand B to zero.
REQ-015 AccClr  out  1  load the accumulator with the product instead of adding to it.
REQ-016 AccEn  out  1  accumulate the lane products.
REQ-017 PushOut  out  1  accumulator holds a complete filter output.

Function
REQ-018 SHALL implement states IDLE, LOAD, PH0, PH1, PH2 and COEF, encoded in 3 bits.
REQ-019 IDLE: if PushCoef=1 and InFlight=0, go to COEF; else if FifoEmpty=0 and PushCoef=0, go to LOAD; else stay in IDLE.
REQ-020 A coefficient request SHALL take priority over a sample when both are pending in IDLE.
REQ-021 LOAD SHALL last exactly 1 cycle, with FifoRd=1 and ShiftEn=1, and then go to PH0.
REQ-022 PH0 -> PH1 -> PH2 SHALL each last 1 cycle.
REQ-023 PHp, lane l SHALL issue pair k=5p+l with AddrA=k, AddrB=28-k and CoefSel=k.
REQ-024 In PH2, lane 4 (k=14) SHALL set AddrB=14 and CenterZero=1; CenterZero SHALL be 0 in every other cycle.
REQ-025 Outside PH0..PH2, AddrA, AddrB and CoefSel SHALL be 0.
REQ-026 The issue marker SHALL be 1 in PH0..PH2, and a first-phase marker SHALL be 1 in PH0.
REQ-027 The issue marker SHALL be delayed PIPE_LAT cycles through a shift register to form AccEn.
REQ-028 The first-phase marker SHALL be delayed PIPE_LAT cycles through a shift register to form AccClr.
REQ-029 PushOut SHALL be 1 for exactly one cycle, PIPE_LAT+1 cycles after the PH2 cycle.
REQ-030 InFlight SHALL be the OR of all valid-pipe bits and the pending PushOut bit.
REQ-031 COEF: CoefWrEn=PushCoef, one write per cycle; go to IDLE on the first cycle with PushCoef=0.
REQ-032 CoefBusy SHALL be the inverse of (state==COEF), so a write is accepted only in COEF.
REQ-033 A PushCoef asserted during LOAD..PH2 SHALL be held off (CoefBusy=1) and SHALL NOT abort the sample.
REQ-034 A request SHALL be held off until all in-flight products of earlier samples have drained.
REQ-035 FifoRd SHALL never be asserted while FifoEmpty=1.
REQ-036 FifoRd SHALL never be asserted outside LOAD.
REQ-037 FifoEmpty rising during PH0..PH2 SHALL have no effect on the sequence in progress.

Reset
REQ-038 Reset=0 SHALL force state IDLE and clear both delay pipes and the PushOut pipe.
REQ-039 During reset, all outputs SHALL be 0 except CoefBusy, which SHALL be 1.
REQ-040 Reset asserted mid-sequence SHALL drop in-flight samples; no PushOut SHALL appear for them after Reset returns to 1.
REQ-041 The first state transition after reset SHALL occur on the first rising Clk edge with Reset=1.

Configuration
REQ-042 Macro FIR_SCHED_BACK2BACK_EN defined: PH2 SHALL go directly to LOAD when FifoEmpty=0 and PushCoef=0, giving 4 cycles/sample.
REQ-043 Macro FIR_SCHED_BACK2BACK_EN defined: in all other cases PH2 SHALL go to IDLE.
REQ-044 Macro FIR_SCHED_BACK2BACK_EN undefined: PH2 SHALL always go to IDLE, giving 5 cycles/sample; all other behaviour is unchanged.

Verification
REQ-045 Single sample: FifoEmpty=0 for one LOAD, PIPE_LAT=4 -> LOAD at t0, PH0..PH2 at t1..t3, AccClr at t5, AccEn at t5..t7, PushOut only at t8.
REQ-046 Address pattern: one sample -> PH0 AddrA lanes {0,1,2,3,4} with AddrB {28,27,26,25,24}; PH1 AddrA {5..9}; PH2 AddrA {10..14} with AddrB {18..14}, CenterZero=1 in PH2 only.
REQ-047 Streaming 10 samples with FifoEmpty=0: with BACK2BACK_EN, LOAD every 4 cycles, 10 PushOuts spaced 4 apart; without it, spacing is 5.
REQ-048 PushCoef raised in PH0 while the sample pipe is busy, held for 29 cycles -> CoefBusy=1 until PushOut plus 1 cycle, then 29 consecutive CoefWrEn pulses with no FifoRd in between.
REQ-049 PushCoef and FifoEmpty=0 together in IDLE with the pipe empty -> COEF first, with LOAD following in the cycle after PushCoef falls.
REQ-050 Reset=0 pulse during PH1 -> all outputs 0 with CoefBusy=1 during reset, no PushOut within 12 cycles after release, then normal restart from IDLE.

Source files
------------

// File: rtl/fir_sched.sv
// rtl/fir_sched.sv - Scheduler for a 29-tap symmetric FIR with five pre-adder/multiplier lanes
//
// Purpose:
//   Sequences one filter output per input sample. LOAD pops the sample and shifts the delay
//   line. PH0..PH2 then issue the 15 symmetric tap pairs over five lanes. Delayed markers
//   tell the accumulator when to clear, when to add, and when its result is complete.
//   Coefficient writes are accepted only in COEF. That state is entered only after all
//   in-flight products have drained.
//
// Optional feature (macro FIR_SCHED_BACK2BACK_EN):
//   defined   - PH2 goes straight to LOAD when another sample is ready (4 cycles/sample).
//   undefined - PH2 always returns to IDLE (5 cycles/sample).
//
// Ports:
//   Clk         in   rising-edge clock
//   Reset       in   asynchronous active-low reset
//   FifoEmpty   in   input sample FIFO empty flag
//   FifoRd      out  pop one I/Q sample
//   ShiftEn     out  shift delay line, popped sample enters entry 0
//   PushCoef    in   coefficient write request, high for every write cycle
//   CoefWrEn    out  coefficient RAM write enable
//   CoefBusy    out  write request not being accepted
//   AddrA       out  5 x 5-bit operand-A tap indices, lane l at [5l+4:5l]
//   AddrB       out  5 x 5-bit operand-B tap indices, same packing
//   CoefSel     out  5 x 4-bit coefficient pair indices, lane l at [4l+3:4l]
//   CenterZero  out  zero lane 4 operand B (center tap is not paired)
//   AccClr      out  load accumulator with product instead of adding
//   AccEn       out  accumulate lane products
//   PushOut     out  accumulator holds a complete output

module fir_sched #(
   parameter int PIPE_LAT = 4,
   parameter int NTAP     = 29
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        FifoEmpty,
   output logic        FifoRd,
   output logic        ShiftEn,
   input  logic        PushCoef,
   output logic        CoefWrEn,
   output logic        CoefBusy,
   output logic [24:0] AddrA,
   output logic [24:0] AddrB,
   output logic [19:0] CoefSel,
   output logic        CenterZero,
   output logic        AccClr,
   output logic        AccEn,
   output logic        PushOut
);

   localparam int LAST = NTAP - 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_PH0  = 3'd2,
      S_PH1  = 3'd3,
      S_PH2  = 3'd4,
      S_COEF = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [PIPE_LAT-1:0]   r_vld_pipe;
   logic [PIPE_LAT-1:0]   r_first_pipe;
   logic [PIPE_LAT:0]     r_push_pipe;
   logic                  w_issue;
   logic                  w_first;
   logic                  w_last;
   logic                  w_in_flight;
   int                    w_phase;

   assign w_issue = (r_state == S_PH0) || (r_state == S_PH1) || (r_state == S_PH2);
   assign w_first = (r_state == S_PH0);
   assign w_last  = (r_state == S_PH2);

   // The pending-output pipe is one stage longer than the product pipe. This keeps a
   // coefficient update off until the cycle after PushOut, once the result has been taken.
   assign w_in_flight = (|r_vld_pipe) || (|r_push_pipe);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state      <= S_IDLE;
         r_vld_pipe   <= '0;
         r_first_pipe <= '0;
         r_push_pipe  <= '0;
      end else begin
         r_state         <= w_state_nxt;
         r_vld_pipe[0]   <= w_issue;
         r_first_pipe[0] <= w_first;
         r_push_pipe[0]  <= w_last;
         for (int i = 1; i < PIPE_LAT; i++) begin
            r_vld_pipe[i]   <= r_vld_pipe[i-1];
            r_first_pipe[i] <= r_first_pipe[i-1];
         end
         for (int i = 1; i <= PIPE_LAT; i++) begin
            r_push_pipe[i] <= r_push_pipe[i-1];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (PushCoef && !w_in_flight) begin
               w_state_nxt = S_COEF;
            end else if (!FifoEmpty && !PushCoef) begin
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: w_state_nxt = S_PH0;
         S_PH0:  w_state_nxt = S_PH1;
         S_PH1:  w_state_nxt = S_PH2;
         S_PH2: begin
`ifdef FIR_SCHED_BACK2BACK_EN
            if (!FifoEmpty && !PushCoef) begin
               w_state_nxt = S_LOAD;
            end else begin
               w_state_nxt = S_IDLE;
            end
`else
            w_state_nxt = S_IDLE;
`endif
         end
         S_COEF: begin
            if (!PushCoef) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Lane l of phase p handles tap pair k = 5p + l, mirrored about the center tap.
   // At k = 14 the mirror index equals the center tap, so operand B is forced to zero.
   always_comb begin
      AddrA      = '0;
      AddrB      = '0;
      CoefSel    = '0;
      CenterZero = 1'b0;
      w_phase    = 0;
      if (r_state == S_PH1) begin
         w_phase = 1;
      end else if (r_state == S_PH2) begin
         w_phase = 2;
      end
      if (w_issue) begin
         for (int l = 0; l < 5; l++) begin
            AddrA[5*l +: 5]   = 5'(5 * w_phase + l);
            AddrB[5*l +: 5]   = 5'(LAST - (5 * w_phase + l));
            CoefSel[4*l +: 4] = 4'(5 * w_phase + l);
         end
      end
      if (w_last) begin
         CenterZero = 1'b1;
      end
   end

   // IDLE enters LOAD only with data present. The extra gate keeps a misbehaving FIFO flag
   // from ever seeing a pop while empty.
   assign FifoRd   = (r_state == S_LOAD) && !FifoEmpty;
   assign ShiftEn  = (r_state == S_LOAD);
   assign CoefWrEn = (r_state == S_COEF) && PushCoef;
   assign CoefBusy = (r_state != S_COEF);
   assign AccEn    = r_vld_pipe[PIPE_LAT-1];
   assign AccClr   = r_first_pipe[PIPE_LAT-1];
   assign PushOut  = r_push_pipe[PIPE_LAT];

endmodule

// File: tb/tb_fir_sched.sv
// tb/tb_fir_sched.sv - Directed self-checking bench for fir_sched

module tb_fir_sched;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        FifoEmpty;
   logic        FifoRd;
   logic        ShiftEn;
   logic        PushCoef;
   logic        CoefWrEn;
   logic        CoefBusy;
   logic [24:0] AddrA;
   logic [24:0] AddrB;
   logic [19:0] CoefSel;
   logic        CenterZero;
   logic        AccClr;
   logic        AccEn;
   logic        PushOut;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_ctl [0:9];
   logic [127:0] rst_vec;

   fir_sched #(.PIPE_LAT(4), .NTAP(29)) dut (
      .Clk(Clk), .Reset(Reset), .FifoEmpty(FifoEmpty), .FifoRd(FifoRd), .ShiftEn(ShiftEn),
      .PushCoef(PushCoef), .CoefWrEn(CoefWrEn), .CoefBusy(CoefBusy), .AddrA(AddrA),
      .AddrB(AddrB), .CoefSel(CoefSel), .CenterZero(CenterZero), .AccClr(AccClr),
      .AccEn(AccEn), .PushOut(PushOut)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {FifoRd, ShiftEn, CoefWrEn, CoefBusy, CenterZero, AccClr, AccEn, PushOut}
   function automatic logic [7:0] ctl();
      return {FifoRd, ShiftEn, CoefWrEn, CoefBusy, CenterZero, AccClr, AccEn, PushOut};
   endfunction

   function automatic logic [127:0] outs();
      return {50'b0, ctl(), AddrA, AddrB, CoefSel};
   endfunction

   function automatic logic [24:0] pack5(input int base, input int step);
      logic [24:0] v;
      v = '0;
      for (int l = 0; l < 5; l++) v[5*l +: 5] = 5'(base + step * l);
      return v;
   endfunction

   function automatic logic [19:0] pack4(input int base);
      logic [19:0] v;
      v = '0;
      for (int l = 0; l < 5; l++) v[4*l +: 4] = 4'(base + l);
      return v;
   endfunction

   task automatic chk_addr(input string tag, input int a_base, input int b_base, input int c_base);
      chk({tag, "_a"}, AddrA, pack5(a_base, 1));
      chk({tag, "_b"}, AddrB, pack5(b_base, -1));
      chk({tag, "_c"}, CoefSel, pack4(c_base));
   endtask

   initial begin
      int nrd, npo, last_rd, last_po, first_rd, cyc, sp;
`ifdef FIR_SCHED_BACK2BACK_EN
      sp = 4;
`else
      sp = 5;
`endif
      // control outputs for LOAD at t0 .. t9 with PIPE_LAT = 4
      exp_ctl[0] = 8'hD0; exp_ctl[1] = 8'h10; exp_ctl[2] = 8'h10; exp_ctl[3] = 8'h18;
      exp_ctl[4] = 8'h10; exp_ctl[5] = 8'h16; exp_ctl[6] = 8'h12; exp_ctl[7] = 8'h12;
      exp_ctl[8] = 8'h11; exp_ctl[9] = 8'h10;
      rst_vec = {50'b0, 8'h10, 70'b0};

      // reset: only CoefBusy high, even with requests pending
      Reset = 1'b0; FifoEmpty = 1'b1; PushCoef = 1'b0;
      repeat (3) tick();
      chk("rst_outs", outs(), rst_vec);
      PushCoef = 1'b1; FifoEmpty = 1'b0;
      tick();
      chk("rst_hold", outs(), rst_vec);
      PushCoef = 1'b0; FifoEmpty = 1'b1;
      Reset = 1'b1;
      tick();
      chk("idle", outs(), rst_vec);

      // single sample timing and address pattern
      FifoEmpty = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("single_t%0d", c), ctl(), exp_ctl[c]);
         if (c == 0) FifoEmpty = 1'b1;
         if (c == 1) chk_addr("ph0", 0, 28, 0);
         if (c == 2) chk_addr("ph1", 5, 23, 5);
         if (c == 3) chk_addr("ph2", 10, 18, 10);
         if (c == 4) chk("post_addr", {AddrA, AddrB, CoefSel}, 70'b0);
      end

      // coefficient request raised in PH0 while a sample is in flight
      FifoEmpty = 1'b0;
      for (int u = 0; u < 10; u++) begin
         tick();
         chk($sformatf("busy_u%0d", u), ctl(), exp_ctl[u]);
         if (u == 1) PushCoef = 1'b1;
      end
      for (int u = 10; u < 39; u++) begin
         tick();
         chk($sformatf("coef_wr_u%0d", u), ctl(), 8'h20);
      end
      PushCoef = 1'b0;
      tick();
      chk("coef_exit_idle", ctl(), 8'h10);
      tick();
      chk("coef_exit_load", ctl(), 8'hD0);
      FifoEmpty = 1'b1;
      repeat (12) tick();

      // request and sample together with pipe empty: coefficient wins
      PushCoef = 1'b1; FifoEmpty = 1'b0;
      tick();
      chk("prio_coef0", ctl(), 8'h20);
      tick();
      chk("prio_coef1", ctl(), 8'h20);
      PushCoef = 1'b0;
      tick();
      chk("prio_idle", ctl(), 8'h10);
      tick();
      chk("prio_load", ctl(), 8'hD0);
      FifoEmpty = 1'b1;
      repeat (12) tick();

      // streaming 10 samples
      nrd = 0; npo = 0; last_rd = 0; last_po = 0; first_rd = 0; cyc = 0;
      FifoEmpty = 1'b0;
      for (int i = 0; i < 150 && npo < 10; i++) begin
         tick();
         cyc++;
         if (FifoRd) begin
            if (nrd > 0) chk("rd_gap", cyc - last_rd, sp);
            else first_rd = cyc;
            last_rd = cyc;
            nrd++;
            if (nrd == 10) FifoEmpty = 1'b1;
         end
         if (PushOut) begin
            if (npo > 0) chk("po_gap", cyc - last_po, sp);
            else chk("po_first_lat", cyc - first_rd, 8);
            last_po = cyc;
            npo++;
         end
      end
      chk("rd_count", nrd, 10);
      chk("po_count", npo, 10);
      FifoEmpty = 1'b1;
      repeat (12) tick();

      // reset during PH1 drops the sample
      FifoEmpty = 1'b0;
      tick();
      FifoEmpty = 1'b1;
      tick();
      tick();
      chk("mid_ph1_a", AddrA, pack5(5, 1));
      Reset = 1'b0;
      #1;
      chk("mid_rst0", outs(), rst_vec);
      tick();
      chk("mid_rst1", outs(), rst_vec);
      Reset = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         chk($sformatf("drop_c%0d", c), {AccEn, PushOut}, 2'b00);
      end
      FifoEmpty = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("restart_t%0d", c), ctl(), exp_ctl[c]);
         if (c == 0) FifoEmpty = 1'b1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
